// File: rtl/pk_stream_unpack.sv
// pk_stream_unpack: byte-serial decoder for the Dilithium public key (rho || packed 10-bit t1).
// Build option: define PK_UNPACK_SHIFT_D_EN to emit each t1 coefficient pre-scaled by 2^13.
module pk_stream_unpack #(
    parameter int K      = 6,
    parameter int N      = 256,
    parameter int COEF_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [255:0]      rho_out,
    output logic              rho_valid,
    output logic              coef_valid,
    output logic [COEF_W-1:0] coef_data,
    output logic [2:0]        coef_poly,
    output logic [7:0]        coef_idx,
    input  logic              coef_ready,
    output logic              done,
    output logic              busy
);

    localparam int GROUPS = K * N / 4;
    localparam int GRP_W  = $clog2(GROUPS + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RHO    = 3'd1;
    localparam logic [2:0] S_GATHER = 3'd2;
    localparam logic [2:0] S_EMIT   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]       state;
    logic [4:0]       byte_cnt;
    logic [GRP_W-1:0] grp_cnt;
    logic [39:0]      group;
    logic [9:0]       raw;
    logic             accept_in;
    logic             accept_coef;
    logic             last_group;
    logic             last_in_group;

    // Verify consumes t1 * 2^D; the scaled build folds that shift into the decoder.
    function automatic logic [COEF_W-1:0] scale_coef(input logic [9:0] c);
`ifdef PK_UNPACK_SHIFT_D_EN
        scale_coef = COEF_W'({c, 13'd0});
`else
        scale_coef = COEF_W'(c);
`endif
    endfunction

    always_comb begin
        in_ready      = (state == S_RHO) || (state == S_GATHER);
        coef_valid    = (state == S_EMIT);
        done          = (state == S_FINISH);
        busy          = (state == S_RHO) || (state == S_GATHER) || (state == S_EMIT);
        accept_in     = in_valid && in_ready;
        accept_coef   = coef_valid && coef_ready;
        last_group    = (grp_cnt == GRP_W'(GROUPS - 1));
        last_in_group = (coef_idx[1:0] == 2'd3);
    end

    // Groups are 4-aligned within a polynomial, so the low bits of coef_idx select the lane.
    always_comb begin
        raw = group[9:0];
        case (coef_idx[1:0])
            2'd0:    raw = group[9:0];
            2'd1:    raw = group[19:10];
            2'd2:    raw = group[29:20];
            default: raw = group[39:30];
        endcase
        coef_data = coef_valid ? scale_coef(raw) : '0;
    end

    // Group buffer: bytes enter at the top so byte j ends up at bits [8j+7:8j].
    always_ff @(posedge clock) begin
        if (state == S_GATHER && accept_in) begin
            group <= {in_data, group[39:8]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            byte_cnt  <= '0;
            grp_cnt   <= '0;
            rho_out   <= '0;
            rho_valid <= 1'b0;
            coef_poly <= '0;
            coef_idx  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_RHO;
                        byte_cnt  <= '0;
                        grp_cnt   <= '0;
                        rho_out   <= '0;
                        rho_valid <= 1'b0;
                        coef_poly <= '0;
                        coef_idx  <= '0;
                    end
                end
                S_RHO: begin
                    if (accept_in) begin
                        rho_out[{byte_cnt, 3'b000} +: 8] <= in_data;
                        if (byte_cnt == 5'd31) begin
                            byte_cnt  <= '0;
                            rho_valid <= 1'b1;
                            state     <= S_GATHER;
                        end else begin
                            byte_cnt <= byte_cnt + 5'd1;
                        end
                    end
                end
                S_GATHER: begin
                    if (accept_in) begin
                        if (byte_cnt == 5'd4) begin
                            byte_cnt <= '0;
                            state    <= S_EMIT;
                        end else begin
                            byte_cnt <= byte_cnt + 5'd1;
                        end
                    end
                end
                S_EMIT: begin
                    if (accept_coef) begin
                        if (last_in_group && last_group) begin
                            coef_idx  <= '0;
                            coef_poly <= '0;
                            grp_cnt   <= '0;
                            state     <= S_FINISH;
                        end else begin
                            if (coef_idx == 8'(N - 1)) begin
                                coef_idx  <= '0;
                                coef_poly <= coef_poly + 3'd1;
                            end else begin
                                coef_idx <= coef_idx + 8'd1;
                            end
                            if (last_in_group) begin
                                grp_cnt <= grp_cnt + GRP_W'(1);
                                state   <= S_GATHER;
                            end
                        end
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pk_stream_unpack.sv
// Scoreboard bench for pk_stream_unpack: directed rho/t1 vectors, stalls, abort and start glitch.
module tb_pk_stream_unpack;

    localparam int K        = 6;
    localparam int N        = 256;
    localparam int COEF_W   = 32;
    localparam int PK_BYTES = 32 + K * 320;
    localparam int NCOEF    = K * N;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic [255:0]      rho_out;
    logic              rho_valid;
    logic              coef_valid;
    logic [COEF_W-1:0] coef_data;
    logic [2:0]        coef_poly;
    logic [7:0]        coef_idx;
    logic              coef_ready;
    logic              done;
    logic              busy;

    always #5 clock = ~clock;

    pk_stream_unpack #(.K(K), .N(N), .COEF_W(COEF_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .rho_out    (rho_out),
        .rho_valid  (rho_valid),
        .coef_valid (coef_valid),
        .coef_data  (coef_data),
        .coef_poly  (coef_poly),
        .coef_idx   (coef_idx),
        .coef_ready (coef_ready),
        .done       (done),
        .busy       (busy)
    );

    typedef struct packed {
        logic [COEF_W-1:0] data;
        logic [2:0]        poly;
        logic [7:0]        idx;
    } exp_t;

    exp_t         sb[$];
    int           vectors    = 0;
    int           miscompares = 0;
    int           n_acc      = 0;
    int           done_cnt   = 0;
    int           stall_cnt  = 0;
    logic [7:0]   pk[PK_BYTES];
    int           t1[NCOEF];
    logic [255:0] exp_rho;
    logic [7:0]   hand_bytes[10] = '{8'hFF, 8'h03, 8'h00, 8'h00, 8'h00,
                                     8'h01, 8'h04, 8'h30, 8'h00, 8'h01};
    int           hand_coefs[8]  = '{1023, 0, 0, 0, 1, 1, 3, 4};
    logic         held;
    logic [255:0] held_val;
    exp_t         mon_e;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    function automatic logic [COEF_W-1:0] expect_val(input int c);
`ifdef PK_UNPACK_SHIFT_D_EN
        return COEF_W'(c) << 13;
`else
        return COEF_W'(c);
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_rho_out"}, rho_out, 0);
        check({tag, "_rho_valid"}, rho_valid, 0);
        check({tag, "_coef_valid"}, coef_valid, 0);
        check({tag, "_coef_data"}, coef_data, 0);
        check({tag, "_coef_poly"}, coef_poly, 0);
        check({tag, "_coef_idx"}, coef_idx, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Bytes are offered with in_valid held high even while the block is emitting.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int budget;
        bit taken;
        if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                in_data = 8'($urandom);
                tick();
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        budget   = 0;
        taken    = 1'b0;
        do begin
            taken = in_ready;
            tick();
            budget++;
        end while (!taken && budget < 400);
        in_valid = 1'b0;
        if (!taken) begin
            check("in_ready_timeout", 0, 1);
            finish_run();
        end
    endtask

    task automatic push_group(input int g);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.data = expect_val(t1[4 * g + k]);
            e.poly = 3'((4 * g + k) / N);
            e.idx  = 8'((4 * g + k) % N);
            sb.push_back(e);
        end
    endtask

    task automatic run_decode(input int seed, input bit hand, input bit gaps,
                              input int abort_at, input int glitch_group);
        int d0, a0, budget;
        logic [39:0] v;
        for (int i = 0; i < NCOEF; i++) t1[i] = (i * seed + (i >> 5) * 3 + seed) & 1023;
        if (hand) for (int i = 0; i < 8; i++) t1[i] = hand_coefs[i];
        for (int i = 0; i < 32; i++) begin
            pk[i] = hand ? 8'(i) : 8'((i * 29 + seed) & 255);
            exp_rho[8 * i +: 8] = pk[i];
        end
        for (int g = 0; g < NCOEF / 4; g++) begin
            v = {10'(t1[4 * g + 3]), 10'(t1[4 * g + 2]), 10'(t1[4 * g + 1]), 10'(t1[4 * g])};
            for (int j = 0; j < 5; j++) pk[32 + 5 * g + j] = v[8 * j +: 8];
        end
        if (hand) for (int j = 0; j < 10; j++) pk[32 + j] = hand_bytes[j];

        d0 = done_cnt;
        a0 = n_acc;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_rho_valid_clr", rho_valid, 0);
        check("start_rho_out_clr", rho_out, 0);
        check("start_in_ready", in_ready, 1);

        for (int b = 0; b < PK_BYTES; b++) begin
            if (b == abort_at) begin
                check("pre_abort_drained", sb.size(), 0);
                check("pre_abort_busy", busy, 1);
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check_idle("abort");
                repeat (4) tick();
                check("abort_no_done", done_cnt - d0, 0);
                return;
            end
            if (b >= 32 && (b - 32) % 5 == 0) begin
                if (abort_at < 0 || b + 5 <= abort_at) push_group((b - 32) / 5);
            end
            if (b == 31) check("rho_valid_early", rho_valid, 0);
            send_byte(pk[b], gaps);
            if (b == 31) begin
                check("rho_valid_rise", rho_valid, 1);
                check("rho_out", rho_out, exp_rho);
                if (hand) check("rho_hand",
                    rho_out, 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100);
            end
            if (glitch_group >= 0 && b == 32 + 5 * glitch_group + 4) begin
                check("glitch_in_emit", coef_valid, 1);
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end

        budget = 0;
        while (done_cnt == d0 && budget < 500) begin
            tick();
            budget++;
        end
        repeat (3) tick();
        check("done_pulses", done_cnt - d0, 1);
        check("busy_after", busy, 0);
        check("coef_count", n_acc - a0, NCOEF);
        check("sb_drained", sb.size(), 0);
        check("rho_valid_hold", rho_valid, 1);
        check("rho_hold", rho_out, exp_rho);
    endtask

    // Sink: holds the sixth coefficient (poly 0 idx 1 of the second group) for 3 cycles,
    // later applies random back-pressure.
    initial begin
        coef_ready = 1'b0;
        forever begin
            tick();
            if (n_acc == 5 && coef_valid && stall_cnt < 3) begin
                coef_ready = 1'b0;
                stall_cnt++;
            end else if (n_acc > 64 && $urandom_range(0, 7) == 0) begin
                coef_ready = 1'b0;
            end else begin
                coef_ready = 1'b1;
            end
        end
    end

    // Monitor: compares each accepted coefficient against the scoreboard queue.
    initial begin
        held = 1'b0;
        held_val = '0;
        forever begin
            @(negedge clock);
            if (held) check("stall_stable", {coef_valid, coef_data, coef_poly, coef_idx}, held_val);
            held     = coef_valid && !coef_ready;
            held_val = {coef_valid, coef_data, coef_poly, coef_idx};
            if (coef_valid && coef_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_coef", {coef_data, coef_poly, coef_idx}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("coef", {coef_data, coef_poly, coef_idx}, mon_e);
                end
                check("in_ready_in_emit", in_ready, 0);
                n_acc++;
            end
            if (done) begin
                done_cnt++;
                check("busy_at_done", busy, 0);
            end
        end
    end

    initial begin
        #900000;
        check("watchdog", 0, 1);
        finish_run();
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        check_idle("reset");
        run_decode(37, 1'b1, 1'b1, -1, -1);
        run_decode(53, 1'b0, 1'b1, 100, -1);
        run_decode(71, 1'b0, 1'b1, -1, 10);
        tick();
        finish_run();
    end

endmodule
